// File: rtl/axis_keying_pkg.sv
// Shared types and timing constants for the AXI-Stream keying scheduler.
// The minimum period covers one full telemetry UART frame at the link prescale.
package axis_keying_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned UART_FRAME_BITS    = 54;
  localparam int unsigned UART_PRESCALE      = 63;
  localparam int unsigned MIN_PERIOD_DEFAULT = UART_FRAME_BITS * UART_PRESCALE;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for a level input: one history register plus AND-NOT.
module edge_rise_det (
  input  logic aclk,
  input  logic aresetn,
  input  logic din,
  output logic rise
);

  logic din_d_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      din_d_reg <= 1'b0;
    end else begin
      din_d_reg <= din;
    end
  end

  assign rise = din & ~din_d_reg;

endmodule

// File: rtl/axis_keying_scheduler.sv
// Appends a pulse key bit as the MSB of each passing AXI-Stream beat; pulse
// period, width and count are measured in transferred beats only.
module axis_keying_scheduler
  import axis_keying_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 39,
  parameter int M_AXIS_TDATA_WIDTH = 40,
  parameter int CNTR_WIDTH         = 32,
  parameter int MIN_PERIOD         = MIN_PERIOD_DEFAULT
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [CNTR_WIDTH-1:0]         cfg_period,
  input  logic [CNTR_WIDTH-1:0]         cfg_width,
  input  logic [CNTR_WIDTH-1:0]         cfg_count,
  input  logic                          start,
  input  logic                          stop,
  output logic                          busy,
  output logic                          done,
  output logic [CNTR_WIDTH-1:0]         pulse_cnt,
  output logic                          s_axis_tready,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid
);

  localparam logic [CNTR_WIDTH-1:0] MIN_PER = CNTR_WIDTH'(MIN_PERIOD);
  localparam logic [CNTR_WIDTH-1:0] ONE     = CNTR_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [CNTR_WIDTH-1:0] phase_reg, phase_next;
  logic [CNTR_WIDTH-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic [CNTR_WIDTH-1:0] per_reg, per_next;
  logic [CNTR_WIDTH-1:0] wid_reg, wid_next;
  logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  stop_pending_reg, stop_pending_next;
  logic                  done_reg, done_next;
  logic                  enbl_reg;

  logic                  start_rise, stop_rise;
  logic                  xfer, key;
  logic [CNTR_WIDTH-1:0] per_eff, wid_eff, pulse_cnt_inc;

  edge_rise_det u_start_det (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (start),
    .rise    (start_rise)
  );

  edge_rise_det u_stop_det (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (stop),
    .rise    (stop_rise)
  );

  assign s_axis_tready = enbl_reg & m_axis_tready;
  assign m_axis_tvalid = enbl_reg & s_axis_tvalid;
  assign xfer          = s_axis_tvalid & s_axis_tready;

  assign key          = (state_reg == RUN) && (phase_reg < wid_reg);
  assign m_axis_tdata = {key, s_axis_tdata};

  // Width is kept below the period so every pulse starts with a fresh key edge.
  assign per_eff       = (cfg_period < MIN_PER) ? MIN_PER : cfg_period;
  assign wid_eff       = (cfg_width == '0) ? ONE :
                         (cfg_width > per_eff - ONE) ? per_eff - ONE : cfg_width;
  assign pulse_cnt_inc = pulse_cnt_reg + ONE;

  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign pulse_cnt = pulse_cnt_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      phase_reg        <= '0;
      pulse_cnt_reg    <= '0;
      per_reg          <= MIN_PER;
      wid_reg          <= ONE;
      cnt_reg          <= '0;
      stop_pending_reg <= 1'b0;
      done_reg         <= 1'b0;
      enbl_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      pulse_cnt_reg    <= pulse_cnt_next;
      per_reg          <= per_next;
      wid_reg          <= wid_next;
      cnt_reg          <= cnt_next;
      stop_pending_reg <= stop_pending_next;
      done_reg         <= done_next;
      enbl_reg         <= 1'b1;
    end
  end

  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    pulse_cnt_next    = pulse_cnt_reg;
    per_next          = per_reg;
    wid_next          = wid_reg;
    cnt_next          = cnt_reg;
    stop_pending_next = stop_pending_reg;
    done_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_rise) begin
          per_next          = per_eff;
          wid_next          = wid_eff;
          cnt_next          = cfg_count;
          phase_next        = '0;
          pulse_cnt_next    = '0;
          stop_pending_next = 1'b0;
          state_next        = RUN;
        end
      end
      RUN: begin
        if (stop_rise) begin
          stop_pending_next = 1'b1;
        end
        if (xfer) begin
          if (phase_reg == per_reg - ONE) begin
            phase_next     = '0;
            pulse_cnt_next = pulse_cnt_inc;
            // Stops only take effect on a period boundary, never mid-pulse.
            if (((cnt_reg != '0) && (pulse_cnt_inc == cnt_reg)) || stop_pending_reg) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            phase_next = phase_reg + ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_keying_scheduler.sv
// Directed bench: stimulus queues expected output beats, a negedge monitor
// pops and compares every transferred beat against them.
module tb_axis_keying_scheduler;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cfg_period, cfg_width, cfg_count;
  logic        start, stop;
  logic        busy, done;
  logic [31:0] pulse_cnt;
  logic        s_axis_tready;
  logic [38:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        m_axis_tready;
  logic [39:0] m_axis_tdata;
  logic        m_axis_tvalid;

  axis_keying_scheduler dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_period    (cfg_period),
    .cfg_width     (cfg_width),
    .cfg_count     (cfg_count),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .pulse_cnt     (pulse_cnt),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          burst_beat = 0;
  int          exp_per = 3402;
  int          exp_wid = 1;
  int          exp_end = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Scoreboard monitor: inputs are stable at negedge, transfer happens next posedge.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got %h required no beat", m_axis_tdata);
      end else begin
        chk("beat", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
      end
    end
    if (aresetn && done) begin
      done_cnt++;
      chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    end
  end

  task automatic run_beats(input int n, input bit gaps);
    logic [38:0] d;
    logic        k;
    logic        xf;
    int          w;
    for (int i = 0; i < n; i++) begin
      d = 39'({$urandom(), $urandom()});
      k = (burst_beat < exp_end) && ((burst_beat % exp_per) < exp_wid);
      if (gaps) begin
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
      exp_q.push_back({k, d});
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      w = 0;
      forever begin
        m_axis_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge aclk);
        xf = s_axis_tready;
        @(posedge aclk); #1;
        if (xf) break;
        w++;
        if (w > 100) begin
          chk("xfer_timeout", 64'd1, 64'd0);
          break;
        end
      end
      burst_beat++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_start(input bit with_stop);
    s_axis_tvalid = 1'b0;
    start = 1'b1;
    stop  = with_stop;
    @(posedge aclk); #1;
    start = 1'b0;
    stop  = 1'b0;
    burst_beat = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic release_reset();
    logic [38:0] d;
    d = 39'({$urandom(), $urandom()});
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    #1;
    chk("tvalid_first_cycle", {63'd0, m_axis_tvalid}, 64'd0);
    chk("tready_first_cycle", {63'd0, s_axis_tready}, 64'd0);
    exp_q.push_back({1'b0, d});
    @(posedge aclk); #1;
    chk("tvalid_second_cycle", {63'd0, m_axis_tvalid}, 64'd1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    $display("reset release: passthrough enabled one cycle after release");
  endtask

  task automatic finish_burst(input string name, input int pulses, input int d0);
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_pulse_cnt"}, {32'd0, pulse_cnt}, 64'(pulses));
    run_beats(8, 1'b0);
    chk({name, "_done_strobes"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_pulse_cnt_hold"}, {32'd0, pulse_cnt}, 64'(pulses));
    $display("%s: burst of %0d pulses, per=%0d wid=%0d", name, pulses, exp_per, exp_wid);
  endtask

  task automatic burst(input string name, input int cp, input int cw, input int cc,
                       input int ep, input int ew, input bit gaps);
    int d0;
    cfg_period = 32'(cp);
    cfg_width  = 32'(cw);
    cfg_count  = 32'(cc);
    do_start(1'b0);
    exp_per = ep;
    exp_wid = ew;
    exp_end = ep * cc;
    d0 = done_cnt;
    run_beats(exp_end, gaps);
    finish_burst(name, cc, d0);
  endtask

  initial begin
    int d0;
    aresetn       = 1'b0;
    cfg_period    = 32'd0;
    cfg_width     = 32'd0;
    cfg_count     = 32'd0;
    start         = 1'b0;
    stop          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_pulse_cnt", {32'd0, pulse_cnt}, 64'd0);
    chk("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    release_reset();

    burst("basic", 4000, 10, 3, 4000, 10, 1'b0);
    burst("clamp_wide", 100, 5000, 1, 3402, 3401, 1'b0);
    burst("clamp_zero", 100, 0, 2, 3402, 1, 1'b0);
    burst("backpressure", 3402, 10, 1, 3402, 10, 1'b1);

    // start+stop together in IDLE, then restart attempt and cfg change mid-burst
    cfg_period = 32'd3402;
    cfg_width  = 32'd5;
    cfg_count  = 32'd2;
    do_start(1'b1);
    exp_per = 3402;
    exp_wid = 5;
    exp_end = 2 * 3402;
    d0 = done_cnt;
    run_beats(100, 1'b0);
    cfg_period = 32'd5000;
    cfg_width  = 32'd50;
    cfg_count  = 32'd1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    chk("edge_busy_after_restart", {63'd0, busy}, 64'd1);
    run_beats(exp_end - 100, 1'b0);
    finish_burst("edge_cases", 2, d0);

    // graceful stop during pulse 7, phase 5
    cfg_period = 32'd3402;
    cfg_width  = 32'd10;
    cfg_count  = 32'd0;
    do_start(1'b0);
    exp_per = 3402;
    exp_wid = 10;
    exp_end = 8 * 3402;
    d0 = done_cnt;
    run_beats(7 * 3402 + 5, 1'b0);
    chk("stop_key_before_stop", {63'd0, m_axis_tdata[39]}, 64'd1);
    stop = 1'b1;
    @(posedge aclk); #1;
    stop = 1'b0;
    chk("stop_busy_pending", {63'd0, busy}, 64'd1);
    run_beats(3402 - 5, 1'b0);
    finish_burst("graceful_stop", 8, d0);

    // asynchronous reset in the middle of a key-high pulse
    cfg_count = 32'd0;
    do_start(1'b0);
    exp_end = 32'h3fff_ffff;
    run_beats(3405, 1'b0);
    chk("mid_pulse_cnt", {32'd0, pulse_cnt}, 64'd1);
    chk("mid_key_high", {63'd0, m_axis_tdata[39]}, 64'd1);
    s_axis_tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("abort_key", {63'd0, m_axis_tdata[39]}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_pulse_cnt", {32'd0, pulse_cnt}, 64'd0);
    chk("abort_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    $display("reset abort: key, busy and pulse_cnt cleared on assertion");
    exp_end = 0;
    repeat (2) @(posedge aclk);
    release_reset();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_keying_scheduler.md
Name: axis_keying_scheduler

Overview:
- Sequences transmit keying for the pulse/telemetry path by appending a key bit as the MSB of each passing AXI-Stream sample.
- That MSB is what the downstream misc reader treats as the pulse key.
- Generates bursts of pulses with programmable period, width and count.
- Timing is counted in transferred samples, so it stays sample-locked to the downstream telemetry and reflect logic.

Parameters:
- S_AXIS_TDATA_WIDTH, 39: input sample width.
- M_AXIS_TDATA_WIDTH, 40: output width; must equal S_AXIS_TDATA_WIDTH+1.
- CNTR_WIDTH, 32: width of the period, width, count and pulse counters.
- MIN_PERIOD, 3402: minimum effective period in samples (54 UART bits x 63 prescale), so that telemetry is never truncated.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_period  in  CNTR_WIDTH  pulse period in samples.
- cfg_width  in  CNTR_WIDTH  key-high samples per pulse.
- cfg_count  in  CNTR_WIDTH  pulses per burst; 0 = run until stopped.
- start  in  1  level; a rising edge starts a burst.
- stop  in  1  level; a rising edge requests a graceful stop.
- busy  out  1  high while the burst is running.
- done  out  1  one-cycle strobe when the burst ends.
- pulse_cnt  out  CNTR_WIDTH  completed pulses since the last start.
- s_axis_tready  out  1.
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH.
- s_axis_tvalid  in  1.
- m_axis_tready  in  1.
- m_axis_tdata  out  M_AXIS_TDATA_WIDTH  {key, s_axis_tdata}.
- m_axis_tvalid  out  1.

Behaviour:
- Reset:
  - aclk is the single clock. aresetn is asynchronous and active-low.
  - During and after reset: state=IDLE, phase=0, pulse_cnt=0, done=0, busy=0, stop_pending=0, enbl=0, start/stop history regs=0.
  - enbl goes to 1 on the first clock after reset release.
  - Reset mid-burst aborts immediately; key is 0 from assertion onward.
- Handshake (combinational passthrough, zero latency):
  - s_axis_tready = enbl & m_axis_tready.
  - m_axis_tvalid = enbl & s_axis_tvalid.
  - xfer = s_axis_tvalid & s_axis_tready.
  - Lower bits of m_axis_tdata equal s_axis_tdata.
- Config latching: on a start edge, latch the effective values:
  - per = max(cfg_period, MIN_PERIOD).
  - wid = clamp(cfg_width, 1, per-1). At least one key-low sample per period guarantees a fresh rising key edge.
  - cnt = cfg_count.
  - Changing cfg_* while busy has no effect.
- Key:
  - key = (state==RUN) & (phase < wid).
  - Combinational from registers, so the beat transferred in a cycle carries the key value of that cycle.
- Edge detect:
  - start_rise = start & ~start_d; stop_rise = stop & ~stop_d.
  - The _d registers update every cycle.
- States:
  - IDLE:
    - key=0.
    - start_rise: latch config, phase=0, pulse_cnt=0, stop_pending=0, go to RUN.
    - A beat transferred in that same cycle carries key=0.
    - stop_rise is ignored. start and stop together: start wins, stop is discarded.
  - RUN:
    - On xfer: if phase==per-1, then phase=0, pulse_cnt++, and the burst ends if (cnt!=0 & pulse_cnt+1==cnt) or stop_pending.
    - On burst end: go to IDLE and pulse done for one cycle.
    - Otherwise on xfer: phase++.
    - No xfer: hold all state.
    - stop_rise sets stop_pending. The current pulse and its off-time always complete, so there is no truncated pulse and no truncated UART frame.
    - start_rise while RUN is ignored.
- Counters:
  - pulse_cnt wraps modulo 2^CNTR_WIDTH when cnt=0.
  - phase never exceeds per-1.
- Status:
  - busy = (state==RUN).
  - done is registered and high for exactly one cycle.
  - pulse_cnt holds its value in IDLE until the next start.

Decomposition:
- Package axis_keying_pkg holds:
  - state enum (IDLE, RUN);
  - localparam UART_FRAME_BITS=54;
  - localparam UART_PRESCALE=63;
  - derived MIN_PERIOD default.
- One sub-module, edge_rise_det (register plus AND-NOT, async active-low reset), instantiated twice, for start and stop.

Test Plan:
- Reset and enable:
  - Assert aresetn=0 mid-burst with a continuous stream → key=0, busy=0, pulse_cnt=0 immediately.
  - m_axis_tvalid=0 in the first cycle after release and passthrough from the next cycle.
- Basic burst:
  - cfg_period=4000, width=10, count=3, start edge, tvalid=tready=1 → key high on beats 0-9, 4000-4009 and 8000-8009.
  - done strobes once after beat 11999; pulse_cnt=3; busy drops in the same cycle done rises.
- Clamping:
  - period=100, width=5000 → per=3402 and wid=3401; key low on exactly 1 beat per period.
  - width=0 → key high on 1 beat per period.
- Backpressure:
  - Random m_axis_tready and s_axis_tvalid gaps → key pattern, counted over transferred beats only, is identical to the gap-free run.
  - Data bits are unchanged.
- Graceful stop:
  - count=0, stop edge at phase=5 of pulse 7 → pulse 7 completes its full width and period.
  - Ends with pulse_cnt=8; no further key beats.
- Edge cases:
  - start and stop rising in the same IDLE cycle → burst runs, stop ignored.
  - start edge while RUN → no restart, phase is not reset.
  - cfg change mid-burst → no effect until the next start.
